// File: rtl/proc_mem_pkg.sv
// -----------------------------------------------------------------------------
// proc_mem_pkg
// Shared definitions for the processor/memory arbiter.
//   src_t        : identifies the requester that issued a memory request
//   MEMREQ_READ  : memory request type for loads and instruction fetches
//   MEMREQ_WRITE : memory request type for stores
// -----------------------------------------------------------------------------
package proc_mem_pkg;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } src_t;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

endpackage

// File: rtl/src_tag_fifo.sv
// -----------------------------------------------------------------------------
// src_tag_fifo
// Small circular FIFO of 1-bit source tags, one per in-flight memory request.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (FIFO becomes empty)
//   i_push       : write i_push_src at the tail this cycle (ignored when full)
//   i_push_src   : tag to store
//   i_pop        : drop the head entry this cycle (ignored when empty)
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
//   o_head       : oldest tag (meaningful only when not empty)
// -----------------------------------------------------------------------------
module src_tag_fifo
  import proc_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  src_t i_push_src,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output src_t o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  src_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      // Simultaneous push and pop leaves the count unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the tag storage is not reset; the pointers and count alone decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_src;
  end

endmodule

// File: rtl/proc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// proc_mem_arbiter
// Shares one memory port between the instruction-fetch (F stage) and data
// (M stage) requesters. Requests are granted combinationally, a source tag is
// recorded per accepted request, and in-order memory responses are routed back
// to the requester that issued them.
//
// Configuration macro:
//   PROC_MEM_ARB_RR_EN : defined   -> round-robin between the two requesters
//                        undefined -> fixed priority, data over fetch
//
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   imemreq_val/rdy/addr            : fetch request handshake and address
//   imemresp_val/data               : fetch response
//   dmemreq_val/rdy/type/addr/wdata : data request (type 0=LW, 1=SW)
//   dmemresp_val/data               : data response
//   memreq_val/rdy/type/addr/wdata  : request to unified memory
//   memresp_val/data                : in-order memory response, no backpressure
//   resp_err                        : sticky flag, response with nothing in flight
// -----------------------------------------------------------------------------
module proc_mem_arbiter
  import proc_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imemreq_val,
  output logic              imemreq_rdy,
  input  logic [ADDR_W-1:0] imemreq_addr,
  output logic              imemresp_val,
  output logic [DATA_W-1:0] imemresp_data,
  input  logic              dmemreq_val,
  output logic              dmemreq_rdy,
  input  logic              dmemreq_type,
  input  logic [ADDR_W-1:0] dmemreq_addr,
  input  logic [DATA_W-1:0] dmemreq_wdata,
  output logic              dmemresp_val,
  output logic [DATA_W-1:0] dmemresp_data,
  output logic              memreq_val,
  input  logic              memreq_rdy,
  output logic              memreq_type,
  output logic [ADDR_W-1:0] memreq_addr,
  output logic [DATA_W-1:0] memreq_wdata,
  input  logic              memresp_val,
  input  logic [DATA_W-1:0] memresp_data,
  output logic              resp_err
);

  logic w_full;
  logic w_empty;
  src_t w_head;
  logic w_can_issue;
  logic w_gnt_d;
  logic w_gnt_i;
  logic w_push;
  src_t w_push_src;
  logic w_pop;
  logic r_resp_err;

  // A full tag FIFO blocks grants even when a response frees a slot this
  // cycle; this keeps the grant path independent of memresp_val.
  assign w_can_issue = ~w_full;

`ifdef PROC_MEM_ARB_RR_EN
  src_t r_last_gnt;

  // NOTE: every signal driven in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_gnt_d = 1'b0;
    w_gnt_i = 1'b0;
    if (w_can_issue) begin
      if (dmemreq_val && imemreq_val) begin
        // Under contention, the source that did not win last time goes.
        w_gnt_d = (r_last_gnt == SRC_IMEM);
        w_gnt_i = (r_last_gnt == SRC_DMEM);
      end else begin
        w_gnt_d = dmemreq_val;
        w_gnt_i = imemreq_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= SRC_DMEM;
    end else if (w_push) begin
      r_last_gnt <= w_push_src;
    end
  end
`else
  // The M-stage request is older than the fetch, so data wins.
  assign w_gnt_d = w_can_issue & dmemreq_val;
  assign w_gnt_i = w_can_issue & imemreq_val & ~dmemreq_val;
`endif

  // Request mux: fetches are always reads with zero write data.
  always_comb begin
    memreq_val   = w_gnt_d | w_gnt_i;
    memreq_type  = MEMREQ_READ;
    memreq_addr  = imemreq_addr;
    memreq_wdata = '0;
    if (w_gnt_d) begin
      memreq_type  = dmemreq_type;
      memreq_addr  = dmemreq_addr;
      memreq_wdata = dmemreq_wdata;
    end
  end

  assign dmemreq_rdy = w_gnt_d & memreq_rdy;
  assign imemreq_rdy = w_gnt_i & memreq_rdy;

  assign w_push     = memreq_val & memreq_rdy;
  assign w_push_src = w_gnt_d ? SRC_DMEM : SRC_IMEM;

  // Responses return in issue order, so the FIFO head names the owner.
  assign w_pop         = memresp_val & ~w_empty;
  assign imemresp_val  = w_pop & (w_head == SRC_IMEM);
  assign dmemresp_val  = w_pop & (w_head == SRC_DMEM);
  assign imemresp_data = memresp_data;
  assign dmemresp_data = memresp_data;

  src_tag_fifo #(
    .DEPTH(MAX_OUTST)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_push_src(w_push_src),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head)
  );

  // A response with nothing in flight is dropped and flagged until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_err <= 1'b0;
    end else if (memresp_val && w_empty) begin
      r_resp_err <= 1'b1;
    end
  end

  assign resp_err = r_resp_err;

endmodule

// File: doc/proc_mem_arbiter.md
Name: proc_mem_arbiter

Overview:
- Shares one unified memory port between the processor's instruction-fetch requester (F stage) and data requester (M stage, LW/SW).
- Arbitrates requests using val/rdy handshakes and tracks in-flight requests in a source-tag FIFO.
- Routes in-order memory responses back to the requester that issued them.
- Sits between the pipelined processor (control and datapath) and the single-ported test memory.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_OUTST, 2, maximum in-flight requests (tag FIFO depth, >=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imemreq_val  in  1  fetch request valid
- imemreq_rdy  out  1  fetch request accepted this cycle
- imemreq_addr  in  ADDR_W  fetch address
- imemresp_val  out  1  fetch response valid
- imemresp_data  out  DATA_W  fetched instruction
- dmemreq_val  in  1  data request valid
- dmemreq_rdy  out  1  data request accepted this cycle
- dmemreq_type  in  1  0=read (LW), 1=write (SW)
- dmemreq_addr  in  ADDR_W  data address
- dmemreq_wdata  in  DATA_W  store data
- dmemresp_val  out  1  data response valid
- dmemresp_data  out  DATA_W  load data (don't-care for writes)
- memreq_val  out  1  memory request valid
- memreq_rdy  in  1  memory accepts request
- memreq_type  out  1  0=read, 1=write
- memreq_addr  out  ADDR_W  memory address
- memreq_wdata  out  DATA_W  memory write data
- memresp_val  in  1  memory response valid (in order, one per request, no backpressure)
- memresp_data  in  DATA_W  memory response data
- resp_err  out  1  sticky: response arrived with no outstanding request

Behaviour:
- **Reset:** tag FIFO empty, outstanding count 0, resp_err=0. With an empty FIFO all *_rdy and *resp_val outputs are 0 unless requests are present.
- **Reset mid-operation:** in-flight tags are discarded. The memory is reset on the same rst.
- **can_issue** = (count < MAX_OUTST). A full FIFO blocks all grants, even if a response pops in the same cycle.
- **Grant (combinational, same cycle):**
  - Fixed priority: data over fetch, because the M-stage request is older.
  - gnt_d = can_issue & dmemreq_val.
  - gnt_i = can_issue & imemreq_val & ~dmemreq_val.
- **Request mux:**
  - memreq_val = gnt_d | gnt_i.
  - memreq_type/addr/wdata come from the granted source. For a fetch grant, type=0 and wdata=0.
- **Ready outputs:**
  - dmemreq_rdy = gnt_d & memreq_rdy.
  - imemreq_rdy = gnt_i & memreq_rdy.
  - A requester must hold val and payload stable until rdy.
- **Push:** on memreq_val & memreq_rdy, the source tag (SRC_IMEM/SRC_DMEM) is pushed at posedge.
- **Pop/route (combinational from memresp_val):**
  - imemresp_val = memresp_val & ~empty & head==SRC_IMEM.
  - dmemresp_val = memresp_val & ~empty & head==SRC_DMEM.
  - Both resp_data outputs = memresp_data. The head pops at posedge.
- **Simultaneous push and pop:** count unchanged, pointers both advance. Pointers wrap modulo MAX_OUTST.
- **Spurious response** (memresp_val while empty): dropped, no resp val asserted, resp_err set until rst.
- **Latency:** request 0 cycles through the arbiter. Response 0 cycles through the arbiter. The fetch-to-response minimum equals the memory latency.

Optional Feature:
- **Macro:** PROC_MEM_ARB_RR_EN.
- **Defined:** round-robin arbitration.
  - A 1-bit last_gnt register is reset to SRC_DMEM and updates on each accepted request.
  - When both requesters are valid, the source not equal to last_gnt wins.
- **Undefined:** fixed data-over-fetch priority; no last_gnt register.

Decomposition:
- **Shared package proc_mem_pkg:**
  - src_t enum (SRC_IMEM=0, SRC_DMEM=1).
  - MEMREQ_READ=0, MEMREQ_WRITE=1.
- **Sub-module src_tag_fifo:**
  - Parameterised depth, 1-bit entries.
  - push/pop/full/empty/head ports.
  - Async reset to empty.

Test Plan:
- **Reset:** assert rst mid-stream with 2 tags outstanding. Require count=0, resp_err=0, imemreq_rdy=dmemreq_rdy=0 with no vals, and the first post-reset response routed per new tags.
- **Contention:** imemreq_val=1 addr=0x100 and dmemreq_val=1 type=0 addr=0x2000 in the same cycle, memreq_rdy=1. Require memreq_addr=0x2000, dmemreq_rdy=1, imemreq_rdy=0. Next cycle: memreq_addr=0x100.
- **Ordering:** issue fetch 0x100, then SW 0x2004 wdata=0xDEADBEEF, then return responses 0x00000013 and 0x0. Require imemresp_val with data 0x00000013, then dmemresp_val.
- **Full:** MAX_OUTST=2, two accepted requests with no responses. Require memreq_val=0 and both rdy=0 even with a response arriving that cycle. One cycle later, require a grant.
- **Backpressure/spurious:** memreq_rdy=0 for 3 cycles. Require no push, payload stable, then accept. Separately, memresp_val with empty FIFO -> resp_err=1 held until rst.
- **RR (PROC_MEM_ARB_RR_EN):** both requesters held valid 4 cycles. Require grants I, D, I, D.
